// File: rtl/mp3_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mp3_ctrl_pkg
// Shared definitions for the MP3 control panel:
//   - transport FSM state encoding (2-bit, legacy-compatible constants)
//   - default attenuation limits for the VS10xx SCI_VOL register
//   - button index enum, registered event bundle and a volume-step helper
// ---------------------------------------------------------------------------
package mp3_ctrl_pkg;

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_PLAYING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;

  localparam logic [7:0] VOL_MIN_ATT_DFLT = 8'h00;  // loudest
  localparam logic [7:0] VOL_MAX_ATT_DFLT = 8'hFE;  // silent

  // Bit position of each raw button inside the packed button vector.
  typedef enum logic [2:0] {
    BTN_PLAY     = 3'd0,
    BTN_NEXT     = 3'd1,
    BTN_PREV     = 3'd2,
    BTN_VOL_UP   = 3'd3,
    BTN_VOL_DOWN = 3'd4
  } btn_idx_e;

  // One-cycle events, registered once before they act on the outputs.
  typedef struct packed {
    logic play_short;
    logic play_long;
    logic next;
    logic prev;
    logic vol_up;
    logic vol_down;
  } evt_t;

  // Saturating attenuation step. Comparisons are done in 9 bits so that
  // neither the subtraction nor the addition can wrap around 8 bits.
  function automatic logic [7:0] vol_next(input logic [7:0] att,
                                          input logic       up,
                                          input logic       down,
                                          input logic [7:0] step,
                                          input logic [7:0] min_att,
                                          input logic [7:0] max_att);
    logic [8:0] w_att9;
    w_att9 = {1'b0, att};
    if (up && !down) begin
      return (w_att9 < ({1'b0, min_att} + {1'b0, step})) ? min_att : att - step;
    end else if (down && !up) begin
      return ((w_att9 + {1'b0, step}) > {1'b0, max_att}) ? max_att : att + step;
    end
    return att;
  endfunction

endpackage

// File: rtl/mp3_ctrl_panel_if.sv
// ---------------------------------------------------------------------------
// mp3_ctrl_panel_if
// Bundle between the user side (raw buttons in, player controls out) and the
// control panel.
//   master : drives the raw buttons, observes the player controls
//   slave  : the control panel itself
// Signals:
//   btn_play/next/prev/vol_up/vol_down  raw asynchronous buttons, 1 = pressed
//   play       1 = player streams data
//   current    selected track id
//   volume     {att,att}, left/right attenuation in SCI_VOL format
//   fsm_state  0 STOPPED, 1 PLAYING, 2 PAUSED
// ---------------------------------------------------------------------------
interface mp3_ctrl_panel_if;
  logic        btn_play;
  logic        btn_next;
  logic        btn_prev;
  logic        btn_vol_up;
  logic        btn_vol_down;
  logic        play;
  logic [2:0]  current;
  logic [15:0] volume;
  logic [1:0]  fsm_state;

  modport master (
    output btn_play, btn_next, btn_prev, btn_vol_up, btn_vol_down,
    input  play, current, volume, fsm_state
  );

  modport slave (
    input  btn_play, btn_next, btn_prev, btn_vol_up, btn_vol_down,
    output play, current, volume, fsm_state
  );
endinterface

// File: rtl/mp3_ctrl_panel_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Conditions one raw push button: 2-flop synchronizer followed by a
// consecutive-cycle filter, plus edge pulses on the debounced level.
// Ports:
//   clk     system clock
//   rst     synchronous reset, active-high (button treated as released)
//   raw_in  asynchronous raw button
//   level   debounced level
//   rise    1-cycle pulse on a debounced 0->1 transition
//   fall    1-cycle pulse on a debounced 1->0 transition
// A clean raw edge reaches 'level' DEBOUNCE_CYCLES+2 clocks later.
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  // NOTE: reset is sampled on the clock edge, and every state flop is
  // assigned with <= so all flops see pre-edge values of their neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= raw_in;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 == r_level) begin
        // Any bounce back to the accepted level restarts the qualification.
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_level & ~r_level_d;
  assign fall  = ~r_level & r_level_d;

endmodule

// File: rtl/mp3_ctrl_panel.sv
// ---------------------------------------------------------------------------
// mp3_ctrl_panel
// User-control front end for the MP3 player: debounces five buttons,
// classifies play presses into SHORT/LONG, runs the STOPPED/PLAYING/PAUSED
// transport FSM and keeps the track and volume registers.
// Ports:
//   clk  system clock (2 MHz, shared with the player)
//   rst  synchronous reset, active-high
//   bus  mp3_ctrl_panel_if.slave: raw buttons in, play/current/volume/
//        fsm_state out (all registered)
// Latency: clean raw edge -> output change = DEBOUNCE_CYCLES+4 clocks
// (2 sync + DEBOUNCE_CYCLES filter + 1 event register + 1 output register).
// ---------------------------------------------------------------------------
module mp3_ctrl_panel
  import mp3_ctrl_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 20000,
  parameter int         LONG_PRESS      = 2000000,
  parameter int         NUM_TRACKS      = 5,
  parameter logic [7:0] VOL_DEFAULT     = 8'h20,
  parameter logic [7:0] VOL_STEP        = 8'h10,
  parameter logic [7:0] VOL_MIN_ATT     = VOL_MIN_ATT_DFLT,
  parameter logic [7:0] VOL_MAX_ATT     = VOL_MAX_ATT_DFLT
) (
  input logic              clk,
  input logic              rst,
  mp3_ctrl_panel_if.slave  bus
);

  localparam int            HW        = $clog2(LONG_PRESS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS - 1);
  localparam logic [2:0]    TRK_LAST  = 3'(NUM_TRACKS - 1);

  // ---- input conditioning -------------------------------------------------
  logic [4:0] w_raw;
  logic [4:0] w_level;
  logic [4:0] w_rise;
  logic [4:0] w_fall;

  assign w_raw = {bus.btn_vol_down, bus.btn_vol_up, bus.btn_prev,
                  bus.btn_next, bus.btn_play};

  for (genvar g = 0; g < 5; g++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw_in (w_raw[g]),
      .level  (w_level[g]),
      .rise   (w_rise[g]),
      .fall   (w_fall[g])
    );
  end

  // Only the play button needs its level and release edge.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, w_level[4:1], w_fall[4:1]};

  // ---- play press classification -----------------------------------------
  // r_hold counts held cycles, the press cycle itself being cycle 1.
  // r_long_fired stays set until the next press so that a release after a
  // LONG produces nothing.
  logic [HW-1:0] r_hold;
  logic          r_long_fired;
  logic          w_long;
  logic          w_short;

  assign w_long  = w_level[BTN_PLAY] & ~w_rise[BTN_PLAY] & ~r_long_fired
                 & (r_hold == HOLD_LAST);
  assign w_short = w_fall[BTN_PLAY] & ~r_long_fired;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold       <= '0;
      r_long_fired <= 1'b0;
    end else if (w_rise[BTN_PLAY]) begin
      r_hold       <= HW'(1);
      r_long_fired <= 1'b0;
    end else if (w_level[BTN_PLAY] && !r_long_fired) begin
      r_hold <= r_hold + 1'b1;
      if (r_hold == HOLD_LAST) r_long_fired <= 1'b1;
    end
  end

  // ---- event register -----------------------------------------------------
  evt_t r_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt <= '0;
    end else begin
      r_evt <= '{play_short: w_short,
                 play_long:  w_long,
                 next:       w_rise[BTN_NEXT],
                 prev:       w_rise[BTN_PREV],
                 vol_up:     w_rise[BTN_VOL_UP],
                 vol_down:   w_rise[BTN_VOL_DOWN]};
    end
  end

  // ---- FSM, track and volume ---------------------------------------------
  logic [1:0] r_state;
  logic       r_play;
  logic [2:0] r_cur;
  logic [7:0] r_att;
  logic [1:0] w_state_nxt;
  logic [2:0] w_cur_nxt;

  // NOTE: every always_comb output gets its hold value first; a path that
  // leaves it unassigned would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (r_evt.play_long) begin
      w_state_nxt = ST_STOPPED;
    end else if (r_evt.play_short) begin
      w_state_nxt = (r_state == ST_PLAYING) ? ST_PAUSED : ST_PLAYING;
    end

    // LONG overrides any track step in the same cycle; next+prev cancel.
    w_cur_nxt = r_cur;
    if (r_evt.play_long) begin
      w_cur_nxt = '0;
    end else if (r_evt.next && !r_evt.prev) begin
      w_cur_nxt = (r_cur == TRK_LAST) ? 3'd0 : r_cur + 3'd1;
    end else if (r_evt.prev && !r_evt.next) begin
      w_cur_nxt = (r_cur == 3'd0) ? TRK_LAST : r_cur - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_STOPPED;
      r_play  <= 1'b0;
      r_cur   <= '0;
      r_att   <= VOL_DEFAULT;
    end else begin
      r_state <= w_state_nxt;
      r_play  <= (w_state_nxt == ST_PLAYING);
      r_cur   <= w_cur_nxt;
      r_att   <= vol_next(r_att, r_evt.vol_up, r_evt.vol_down,
                          VOL_STEP, VOL_MIN_ATT, VOL_MAX_ATT);
    end
  end

  assign bus.play      = r_play;
  assign bus.current   = r_cur;
  assign bus.volume    = {r_att, r_att};
  assign bus.fsm_state = r_state;

endmodule

// File: tb/tb_mp3_ctrl_panel.sv
// ---------------------------------------------------------------------------
// tb_mp3_ctrl_panel
// Directed and randomized button sequences. The reference model works at
// press level: each completed press (or combination of simultaneous presses)
// updates an abstract player state with the documented rules, and the DUT
// outputs are compared after the press has settled. A few steps also check
// the exact edge-to-output latency.
// ---------------------------------------------------------------------------
module tb_mp3_ctrl_panel;

  localparam int D    = 4;
  localparam int LP   = 40;
  localparam int NT   = 5;
  localparam int STEP = 16;
  localparam int VMIN = 0;
  localparam int VMAX = 254;
  localparam int VDEF = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mp3_ctrl_panel_if bus ();

  mp3_ctrl_panel #(
    .DEBOUNCE_CYCLES (D),
    .LONG_PRESS      (LP),
    .NUM_TRACKS      (NT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 stopped, 1 playing, 2 paused.
  int m_st;
  int m_cur;
  int m_att;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mask bits: 0 play, 1 next, 2 prev, 3 vol_up, 4 vol_down
  task automatic set_btns(input logic [4:0] m);
    bus.btn_play     = m[0];
    bus.btn_next     = m[1];
    bus.btn_prev     = m[2];
    bus.btn_vol_up   = m[3];
    bus.btn_vol_down = m[4];
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_cur = 0;
    m_att = VDEF;
  endtask

  task automatic model_apply(input logic [4:0] m, input bit is_long);
    if (m[1] && !m[2]) m_cur = (m_cur + 1) % NT;
    if (m[2] && !m[1]) m_cur = (m_cur + NT - 1) % NT;
    if (m[3] && !m[4]) m_att = (m_att - STEP < VMIN) ? VMIN : m_att - STEP;
    if (m[4] && !m[3]) m_att = (m_att + STEP > VMAX) ? VMAX : m_att + STEP;
    if (m[0]) begin
      if (is_long) begin
        m_st  = 0;
        m_cur = 0;
      end else begin
        m_st = (m_st == 1) ? 2 : 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".play"},    32'(bus.play),      32'(m_st == 1));
    check({tag, ".current"}, 32'(bus.current),   32'(m_cur));
    check({tag, ".volume"},  32'(bus.volume),    32'(m_att * 257));
    check({tag, ".state"},   32'(bus.fsm_state), 32'(m_st));
  endtask

  // Hold the buttons in 'm' for 'cyc' clocks, release, let everything settle.
  task automatic action(input string tag, input logic [4:0] m, input int cyc);
    set_btns(m);
    tick(cyc);
    set_btns(5'b0);
    tick(D + 6);
    model_apply(m, cyc >= LP + 5);
    check_all(tag);
  endtask

  initial begin
    set_btns(5'b0);
    rst = 1'b1;

    // 1. reset
    tick(3);
    check("rst.play",    32'(bus.play),      32'd0);
    check("rst.current", 32'(bus.current),   32'd0);
    check("rst.volume",  32'(bus.volume),    32'h2020);
    check("rst.state",   32'(bus.fsm_state), 32'd0);
    rst = 1'b0;
    tick(2);
    model_reset();
    check_all("post_rst");

    // 2. short presses toggle play/pause
    action("play1", 5'b00001, 10);
    check("play1_k", 32'(bus.play), 32'd1);
    action("play2", 5'b00001, 10);
    check("play2_k", 32'(bus.fsm_state), 32'd2);
    action("play3", 5'b00001, 10);
    check("play3_k", 32'(bus.play), 32'd1);

    // 3. bouncy press: one SHORT, exact latency after release
    set_btns(5'b00001); tick(2);
    set_btns(5'b00000); tick(2);
    set_btns(5'b00001); tick(2);
    set_btns(5'b00000); tick(2);
    set_btns(5'b00001); tick(10);
    check("bounce_hold", 32'(bus.play), 32'd1);
    set_btns(5'b00000);
    tick(D + 3);
    check("bounce_early", 32'(bus.play), 32'd1);
    tick(1);
    check("bounce_exact", 32'(bus.play), 32'd0);
    tick(6);
    m_st = 2;
    check_all("bounce");

    // 4. track wrap
    action("prev_wrap", 5'b00100, 10);
    check("prev_wrap_k", 32'(bus.current), 32'd4);
    set_btns(5'b00010);
    tick(D + 3);
    check("next_early", 32'(bus.current), 32'd4);
    tick(1);
    check("next_exact", 32'(bus.current), 32'd0);
    tick(6);
    set_btns(5'b00000);
    tick(D + 6);
    model_apply(5'b00010, 1'b0);
    check_all("next_wrap");
    action("prev_wrap2", 5'b00100, 10);
    action("next_prev", 5'b00110, 10);
    check("next_prev_k", 32'(bus.current), 32'd4);

    // 5. volume saturation
    action("up1", 5'b01000, 10);
    check("up1_k", 32'(bus.volume), 32'h1010);
    action("up2", 5'b01000, 10);
    check("up2_k", 32'(bus.volume), 32'h0000);
    action("up3", 5'b01000, 10);
    check("up3_k", 32'(bus.volume), 32'h0000);
    for (int i = 0; i < 17; i++) action("down", 5'b10000, 8);
    check("down_k", 32'(bus.volume), 32'hFEFE);
    action("up_down", 5'b11000, 10);

    // 6. long press while playing track 3, then reset mid-hold
    action("resume", 5'b00001, 10);
    action("to_trk3", 5'b00100, 10);
    check("trk3_k", 32'(bus.current), 32'd3);
    action("long", 5'b00001, 50);
    check("long_play",  32'(bus.play),      32'd0);
    check("long_cur",   32'(bus.current),   32'd0);
    check("long_state", 32'(bus.fsm_state), 32'd0);

    action("pre_rst_vol", 5'b10000, 10);
    action("pre_rst_play", 5'b00001, 10);
    set_btns(5'b00001);
    tick(20);
    rst = 1'b1;
    tick(2);
    set_btns(5'b00000);
    tick(3);
    rst = 1'b0;
    tick(D + 10 + LP);
    model_reset();
    check_all("rst_hold");

    // 7. random combinations
    for (int i = 0; i < 40; i++) begin
      logic [4:0] m;
      int         cyc;
      m   = 5'($urandom_range(1, 31));
      cyc = (m[0] && ($urandom_range(0, 3) == 0)) ? int'($urandom_range(50, 60))
                                                  : int'($urandom_range(8, 20));
      action("rand", m, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
